// File: rtl/templatized_alu_pkg.sv
// Shared types and constants for the ALU dispatch stage and its neighbours.
// Covers the unit indices, dispatch FSM states and response status codes.
package templatized_alu_pkg;

    localparam int NUM_UNITS  = 3;
    localparam int UNIT_ADD   = 2;
    localparam int UNIT_LOGIC = 1;
    localparam int UNIT_SHIFT = 0;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        ISSUE,
        WAIT,
        RESP
    } dispatch_state_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_ILLEGAL = 2'b01,
        ST_TIMEOUT = 2'b10
    } status_e;

    // True when exactly one unit is enabled.
    function automatic logic is_onehot(input logic [NUM_UNITS-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/templatized_alu_dispatch_timer.sv
// Saturating cycle counter used to bound how long a functional unit may run.
// The expired flag is high while the count equals TIMEOUT_CYCLES.
module templatized_alu_dispatch_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] MAX_COUNT = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != MAX_COUNT)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == MAX_COUNT);

endmodule

// File: rtl/templatized_alu_dispatch.sv
// Issue stage in front of the ALU functional units: accepts one request, launches
// the unit chosen by the control block, waits for it (bounded) and returns a response.
module templatized_alu_dispatch
    import templatized_alu_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 in_op_code,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    output logic [2:0]                 ctrl_op_code,
    input  logic [NUM_UNITS-1:0]       ctrl_en,
    output logic [NUM_UNITS-1:0]       unit_start,
    output logic [2:0]                 unit_op_code,
    output logic [WIDTH-1:0]           unit_a,
    output logic [WIDTH-1:0]           unit_b,
    input  logic [NUM_UNITS-1:0]       unit_done,
    input  logic [NUM_UNITS*WIDTH-1:0] unit_result,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_result,
    output logic [1:0]                 out_status
);

    dispatch_state_e        state, state_nxt;
    logic [2:0]             op_r;
    logic [WIDTH-1:0]       a_r, b_r;
    logic [NUM_UNITS-1:0]   sel_r;
    logic [WIDTH-1:0]       sel_result;
    logic                   done_sel;
    logic                   en_legal;
    logic                   timer_clr, timer_en, timer_expired;

    templatized_alu_dispatch_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (timer_expired)
    );

    assign en_legal = is_onehot(ctrl_en);
    assign done_sel = |(unit_done & sel_r);

    // sel_r is one-hot, so OR-ing the masked slices yields the selected result.
    always_comb begin
        sel_result = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (sel_r[i]) begin
                sel_result = sel_result | unit_result[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Timer is zero in DECODE and steps to 1 on entry to ISSUE, so it counts
    // cycles spent waiting with ISSUE as cycle 1. Done is checked before expiry.
    always_comb begin
        state_nxt = state;
        timer_clr = 1'b0;
        timer_en  = 1'b0;
        case (state)
            IDLE: begin
                timer_clr = 1'b1;
                if (in_valid) begin
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
                if (en_legal) begin
                    state_nxt = ISSUE;
                    timer_en  = 1'b1;
                end else begin
                    state_nxt = RESP;
                end
            end
            ISSUE, WAIT: begin
                if (done_sel || timer_expired) begin
                    state_nxt = RESP;
                end else begin
                    state_nxt = WAIT;
                    timer_en  = 1'b1;
                end
            end
            RESP: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r       <= '0;
            a_r        <= '0;
            b_r        <= '0;
            sel_r      <= '0;
            out_result <= '0;
            out_status <= ST_OK;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_r <= in_op_code;
                        a_r  <= in_a;
                        b_r  <= in_b;
                    end
                end
                DECODE: begin
                    if (en_legal) begin
                        sel_r <= ctrl_en;
                    end else begin
                        out_result <= '0;
                        out_status <= ST_ILLEGAL;
                    end
                end
                ISSUE, WAIT: begin
                    if (done_sel) begin
                        out_result <= sel_result;
                        out_status <= ST_OK;
                    end else if (timer_expired) begin
                        out_result <= '0;
                        out_status <= ST_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready     = (state == IDLE);
    assign out_valid    = (state == RESP);
    assign unit_start   = (state == ISSUE) ? sel_r : '0;
    assign ctrl_op_code = op_r;
    assign unit_op_code = op_r;
    assign unit_a       = a_r;
    assign unit_b       = b_r;

endmodule

// File: tb/tb_templatized_alu_dispatch.sv
// Directed bench for templatized_alu_dispatch with the default 32-bit width
// and a 16-cycle unit timeout.
module tb_templatized_alu_dispatch;
    import templatized_alu_pkg::*;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [2:0]     in_op_code;
    logic [W-1:0]   in_a, in_b;
    logic [2:0]     ctrl_op_code;
    logic [2:0]     ctrl_en;
    logic [2:0]     unit_start;
    logic [2:0]     unit_op_code;
    logic [W-1:0]   unit_a, unit_b;
    logic [2:0]     unit_done;
    logic [3*W-1:0] unit_result;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_result;
    logic [1:0]     out_status;

    int total = 0;
    int bad   = 0;

    templatized_alu_dispatch #(.WIDTH(W), .TIMEOUT_CYCLES(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op_code   (in_op_code),
        .in_a         (in_a),
        .in_b         (in_b),
        .ctrl_op_code (ctrl_op_code),
        .ctrl_en      (ctrl_en),
        .unit_start   (unit_start),
        .unit_op_code (unit_op_code),
        .unit_a       (unit_a),
        .unit_b       (unit_b),
        .unit_done    (unit_done),
        .unit_result  (unit_result),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_status   (out_status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one cycle; returns with the DUT in DECODE.
    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid   = 1'b1;
        in_op_code = op;
        in_a       = a;
        in_b       = b;
        cyc();
        in_valid   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_op_code  = '0;
        in_a        = '0;
        in_b        = '0;
        ctrl_en     = '0;
        unit_done   = '0;
        unit_result = '0;
        out_ready   = 1'b0;

        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_unit_start", unit_start, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_status", out_status, 0);
        chk("rst_ctrl_op", ctrl_op_code, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("idle_in_ready", in_ready, 1);

        // Zero-latency add: out_valid on the third cycle after accept.
        send(3'b000, 32'd5, 32'd3);
        chk("add_decode_in_ready", in_ready, 0);
        chk("add_ctrl_op", ctrl_op_code, 3'b000);
        chk("add_decode_start", unit_start, 0);
        ctrl_en = 3'b100;
        cyc();
        chk("add_issue_start", unit_start, 3'b100);
        chk("add_unit_a", unit_a, 5);
        chk("add_unit_b", unit_b, 3);
        chk("add_issue_valid", out_valid, 0);
        unit_done = 3'b100;
        unit_result[UNIT_ADD*W +: W] = 32'd8;
        cyc();
        unit_done = 3'b000;
        chk("add_resp_valid", out_valid, 1);
        chk("add_resp_start", unit_start, 0);
        chk("add_result", out_result, 8);
        chk("add_status", out_status, ST_OK);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("add_back_idle", in_ready, 1);
        chk("add_valid_clr", out_valid, 0);

        // Illegal op with no unit enabled.
        send(3'b111, 32'd1, 32'd2);
        ctrl_en = 3'b000;
        cyc();
        chk("ill0_valid", out_valid, 1);
        chk("ill0_start", unit_start, 0);
        chk("ill0_result", out_result, 0);
        chk("ill0_status", out_status, ST_ILLEGAL);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;

        // Illegal: two units enabled at once.
        send(3'b111, 32'd1, 32'd2);
        ctrl_en = 3'b011;
        cyc();
        chk("ill2_valid", out_valid, 1);
        chk("ill2_start", unit_start, 0);
        chk("ill2_status", out_status, ST_ILLEGAL);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;

        // Shift unit completing on cycle 16 from ISSUE, coincident with the timer limit.
        send(3'b011, 32'h0F, 32'd4);
        ctrl_en = 3'b001;
        cyc();
        chk("shf_issue_start", unit_start, 3'b001);
        for (int i = 2; i <= 16; i++) begin
            cyc();
            if (i == 2) chk("shf_wait_start", unit_start, 0);
        end
        chk("shf_c16_valid", out_valid, 0);
        unit_done = 3'b001;
        unit_result[UNIT_SHIFT*W +: W] = 32'hF0;
        cyc();
        unit_done = 3'b000;
        chk("shf_valid", out_valid, 1);
        chk("shf_result", out_result, 32'hF0);
        chk("shf_status", out_status, ST_OK);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;

        // Same unit never finishes: timeout one cycle after cycle 16.
        send(3'b011, 32'h0F, 32'd4);
        ctrl_en = 3'b001;
        cyc();
        for (int i = 2; i <= 16; i++) cyc();
        chk("to_c16_valid", out_valid, 0);
        cyc();
        chk("to_valid", out_valid, 1);
        chk("to_result", out_result, 0);
        chk("to_status", out_status, ST_TIMEOUT);
        unit_done = 3'b001;
        unit_result[UNIT_SHIFT*W +: W] = 32'hAB;
        cyc();
        chk("to_late_result", out_result, 0);
        chk("to_late_status", out_status, ST_TIMEOUT);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        cyc();
        unit_done = 3'b000;
        chk("to_late_idle_valid", out_valid, 0);
        chk("to_late_idle_ready", in_ready, 1);

        // Stray done from the logic unit while add is selected, then backpressure.
        send(3'b001, 32'hC, 32'hA);
        ctrl_en = 3'b100;
        cyc();
        unit_done = 3'b010;
        unit_result[UNIT_LOGIC*W +: W] = 32'h55;
        cyc();
        unit_done = 3'b000;
        chk("stray_valid", out_valid, 0);
        cyc();
        unit_done = 3'b100;
        unit_result[UNIT_ADD*W +: W] = 32'h77;
        cyc();
        unit_done = 3'b000;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_result", out_result, 32'h77);
            chk("bp_in_ready", in_ready, 0);
            cyc();
        end
        chk("bp_status", out_status, ST_OK);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("bp_release", in_ready, 1);

        // Asynchronous reset while waiting on the logic unit.
        send(3'b010, 32'h11, 32'h22);
        ctrl_en = 3'b010;
        cyc();
        cyc();
        cyc();
        chk("rw_pre_valid", out_valid, 0);
        chk("rw_pre_a", unit_a, 32'h11);
        rst_n = 1'b0;
        #1;
        chk("rw_in_ready", in_ready, 1);
        chk("rw_start", unit_start, 0);
        chk("rw_valid", out_valid, 0);
        chk("rw_op", ctrl_op_code, 0);
        chk("rw_a", unit_a, 0);
        chk("rw_b", unit_b, 0);
        chk("rw_result", out_result, 0);
        #2;
        rst_n = 1'b1;
        unit_done = 3'b010;
        unit_result[UNIT_LOGIC*W +: W] = 32'h99;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rw_post_valid", out_valid, 0);
            chk("rw_post_ready", in_ready, 1);
        end
        chk("rw_post_result", out_result, 0);
        unit_done = 3'b000;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
